// File: rtl/cpu_types_pkg.sv
// Shared CPU types for the pipeline control path.
// Latency: n/a (types, constants and pure helper functions only).
// Backpressure: n/a.
package cpu_types_pkg;

    typedef logic [4:0]  regbits_t;
    typedef logic [31:0] word_t;

    // Hazard unit control state.
    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DWAIT  = 2'd1,
        HALTED = 2'd2
    } hazard_state_t;

    // One cycle's worth of pipeline control, bundled so the state machine
    // can build it field by field and drive all ports from one place.
    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic idex_en;
        logic exmem_en;
        logic memwb_en;
        logic ifid_flush;
        logic idex_flush;
        logic exmem_flush;
        logic memwb_flush;
        logic dwait;
        logic halted;
    } hazard_ctrl_t;

    // Everything moves forward, nothing is squashed.
    function automatic hazard_ctrl_t ctrl_advance();
        hazard_ctrl_t c;
        c             = '0;
        c.pc_en       = 1'b1;
        c.ifid_en     = 1'b1;
        c.idex_en     = 1'b1;
        c.exmem_en    = 1'b1;
        c.memwb_en    = 1'b1;
        return c;
    endfunction

    // Front of the pipe held on a dcache wait; MEM/WB takes a bubble so the
    // stalled MEM instruction does not retire twice.
    function automatic hazard_ctrl_t ctrl_dfreeze();
        hazard_ctrl_t c;
        c             = '0;
        c.memwb_en    = 1'b1;
        c.memwb_flush = 1'b1;
        c.dwait       = 1'b1;
        return c;
    endfunction

    // Nothing moves once halted.
    function automatic hazard_ctrl_t ctrl_halted();
        hazard_ctrl_t c;
        c        = '0;
        c.halted = 1'b1;
        return c;
    endfunction

    // While reset is held every latch loads a NOP and the PC stays put.
    function automatic hazard_ctrl_t ctrl_reset();
        hazard_ctrl_t c;
        c             = ctrl_advance();
        c.pc_en       = 1'b0;
        c.ifid_flush  = 1'b1;
        c.idex_flush  = 1'b1;
        c.exmem_flush = 1'b1;
        c.memwb_flush = 1'b1;
        return c;
    endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// Bundle of hazard-unit signals between the control unit and the datapath.
// Latency: n/a (wires only).
// Backpressure: n/a; optional counters present with HAZARD_PERF_CNT_EN.
interface hazard_unit_if
    import cpu_types_pkg::*;
(
    input logic CLK
);
    logic     RST;
    regbits_t id_rs;
    regbits_t id_rt;
    logic     id_use_rs;
    logic     id_use_rt;
    regbits_t ex_rt;
    logic     ex_memread;
    logic     ex_pcsrc;
    logic     mem_dren;
    logic     mem_dwen;
    logic     dhit;
    logic     ihit;
    logic     mem_halt;
    logic     pc_en;
    logic     ifid_en;
    logic     idex_en;
    logic     exmem_en;
    logic     memwb_en;
    logic     ifid_flush;
    logic     idex_flush;
    logic     exmem_flush;
    logic     memwb_flush;
    logic     dwait;
    logic     halted;
    logic     timeout_err;
`ifdef HAZARD_PERF_CNT_EN
    word_t    stall_lu_cnt;
    word_t    stall_dw_cnt;
    word_t    flush_br_cnt;
`endif

    // Unit side: consumes pipeline status, produces latch control.
    modport hu (
        input  CLK, RST,
        input  id_rs, id_rt, id_use_rs, id_use_rt, ex_rt, ex_memread, ex_pcsrc,
        input  mem_dren, mem_dwen, dhit, ihit, mem_halt,
        output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
        output ifid_flush, idex_flush, exmem_flush, memwb_flush,
        output dwait, halted, timeout_err
`ifdef HAZARD_PERF_CNT_EN
        ,
        output stall_lu_cnt, stall_dw_cnt, flush_br_cnt
`endif
    );

    // Datapath side: mirror of the unit side.
    modport dp (
        input  CLK,
        output RST,
        output id_rs, id_rt, id_use_rs, id_use_rt, ex_rt, ex_memread, ex_pcsrc,
        output mem_dren, mem_dwen, dhit, ihit, mem_halt,
        input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
        input  ifid_flush, idex_flush, exmem_flush, memwb_flush,
        input  dwait, halted, timeout_err
`ifdef HAZARD_PERF_CNT_EN
        ,
        input  stall_lu_cnt, stall_dw_cnt, flush_br_cnt
`endif
    );

endinterface

// File: rtl/hazard_loaduse_detect.sv
// Load-use dependence detector between the ID and EX instructions.
// Latency: purely combinational, same cycle.
// Backpressure: none; the caller decides what to do with lu_hit.
module hazard_loaduse_detect
    import cpu_types_pkg::*;
(
    input  regbits_t id_rs,
    input  regbits_t id_rt,
    input  logic     id_use_rs,
    input  logic     id_use_rt,
    input  regbits_t ex_rt,
    input  logic     ex_memread,
    output logic     lu_hit
);

    logic rs_match;
    logic rt_match;

    // A load into $0 produces nothing to wait for, so it never matches.
    always_comb begin
        rs_match = id_use_rs && (id_rs == ex_rt);
        rt_match = id_use_rt && (id_rt == ex_rt);
        lu_hit   = ex_memread && (ex_rt != '0) && (rs_match || rt_match);
    end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard control: stalls, redirect flushes, cache freezes, halt.
// Latency: outputs combinational from state and inputs; state/timer registered.
// Backpressure: dcache miss freezes PC..EX/MEM; HAZARD_PERF_CNT_EN adds counters.
module hazard_unit
    import cpu_types_pkg::*;
#(
    parameter int WAIT_TIMEOUT = 255,
    parameter int TMR_W        = 8
) (
    input  logic     CLK,
    input  logic     RST,
    input  regbits_t id_rs,
    input  regbits_t id_rt,
    input  logic     id_use_rs,
    input  logic     id_use_rt,
    input  regbits_t ex_rt,
    input  logic     ex_memread,
    input  logic     ex_pcsrc,
    input  logic     mem_dren,
    input  logic     mem_dwen,
    input  logic     dhit,
    input  logic     ihit,
    input  logic     mem_halt,
    output logic     pc_en,
    output logic     ifid_en,
    output logic     idex_en,
    output logic     exmem_en,
    output logic     memwb_en,
    output logic     ifid_flush,
    output logic     idex_flush,
    output logic     exmem_flush,
    output logic     memwb_flush,
    output logic     dwait,
    output logic     halted,
    output logic     timeout_err
`ifdef HAZARD_PERF_CNT_EN
    ,
    output word_t    stall_lu_cnt,
    output word_t    stall_dw_cnt,
    output word_t    flush_br_cnt
`endif
);

    localparam logic [TMR_W-1:0] TMR_MAX = '1;
    localparam logic [TMR_W-1:0] TMO_VAL = TMR_W'(WAIT_TIMEOUT);

    hazard_state_t    state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [TMR_W-1:0] timer_inc;
    logic             tmo_err_q, tmo_err_d;
    hazard_ctrl_t     ctrl;
    logic             lu_hit;
    logic             d_miss;

    hazard_loaduse_detect u_lu (
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_use_rs  (id_use_rs),
        .id_use_rt  (id_use_rt),
        .ex_rt      (ex_rt),
        .ex_memread (ex_memread),
        .lu_hit     (lu_hit)
    );

    // Data access outstanding in MEM that the dcache has not finished.
    assign d_miss    = (mem_dren || mem_dwen) && !dhit;
    assign timer_inc = (timer_q == TMR_MAX) ? timer_q : timer_q + TMR_W'(1);

    // Next state, wait timer, watchdog and this cycle's latch control.
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        tmo_err_d = tmo_err_q;
        ctrl      = ctrl_advance();
        case (state_q)
            RUN: begin
                timer_d = '0;
                if (d_miss) begin
                    ctrl    = ctrl_dfreeze();
                    state_d = DWAIT;
                end else begin
                    // Redirect squashes the wrong-path IF/ID and ID/EX contents,
                    // which makes any load-use or fetch miss there irrelevant.
                    if (ex_pcsrc) begin
                        ctrl.ifid_flush = 1'b1;
                        ctrl.idex_flush = 1'b1;
                    end else if (lu_hit) begin
                        ctrl.pc_en      = 1'b0;
                        ctrl.ifid_en    = 1'b0;
                        ctrl.idex_flush = 1'b1;
                    end else if (!ihit) begin
                        ctrl.pc_en      = 1'b0;
                        ctrl.ifid_flush = 1'b1;
                    end
                    // MEM/WB still advances this cycle so the halt retires.
                    if (mem_halt) begin
                        state_d = HALTED;
                    end
                end
            end
            DWAIT: begin
                if (dhit) begin
                    ctrl.pc_en = ihit;
                    ctrl.dwait = 1'b1;
                    state_d    = RUN;
                    timer_d    = '0;
                end else begin
                    ctrl    = ctrl_dfreeze();
                    timer_d = timer_inc;
                    if ((WAIT_TIMEOUT != 0) && (timer_d == TMO_VAL)) begin
                        tmo_err_d = 1'b1;
                    end
                end
            end
            HALTED: begin
                ctrl = ctrl_halted();
            end
            default: begin
                ctrl    = ctrl_advance();
                state_d = RUN;
            end
        endcase
        if (RST) begin
            ctrl = ctrl_reset();
        end
    end

    // State, timer and sticky watchdog flag.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= RUN;
            timer_q   <= '0;
            tmo_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            tmo_err_q <= tmo_err_d;
        end
    end

    assign pc_en       = ctrl.pc_en;
    assign ifid_en     = ctrl.ifid_en;
    assign idex_en     = ctrl.idex_en;
    assign exmem_en    = ctrl.exmem_en;
    assign memwb_en    = ctrl.memwb_en;
    assign ifid_flush  = ctrl.ifid_flush;
    assign idex_flush  = ctrl.idex_flush;
    assign exmem_flush = ctrl.exmem_flush;
    assign memwb_flush = ctrl.memwb_flush;
    assign dwait       = ctrl.dwait;
    assign halted      = ctrl.halted;
    assign timeout_err = tmo_err_q;

`ifdef HAZARD_PERF_CNT_EN
    word_t lu_cnt_q, dw_cnt_q, br_cnt_q;
    logic  lu_evt, dw_evt, br_evt;

    // Events mirror the branches taken in the RUN/DWAIT decode above.
    assign br_evt = (state_q == RUN) && !d_miss && ex_pcsrc;
    assign lu_evt = (state_q == RUN) && !d_miss && !ex_pcsrc && lu_hit;
    assign dw_evt = ctrl.dwait;

    // Free-running wrap-around counters; no events occur while halted.
    always_ff @(posedge CLK) begin
        if (RST) begin
            lu_cnt_q <= '0;
            dw_cnt_q <= '0;
            br_cnt_q <= '0;
        end else begin
            if (lu_evt) lu_cnt_q <= lu_cnt_q + 32'd1;
            if (dw_evt) dw_cnt_q <= dw_cnt_q + 32'd1;
            if (br_evt) br_cnt_q <= br_cnt_q + 32'd1;
        end
    end

    assign stall_lu_cnt = lu_cnt_q;
    assign stall_dw_cnt = dw_cnt_q;
    assign flush_br_cnt = br_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
module tb_hazard_unit;

    // Output vector order:
    // {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
    //  ifid_flush, idex_flush, exmem_flush, memwb_flush, dwait, halted, timeout_err}
    localparam logic [11:0] E_NORMAL  = 12'b1_1111_0000_000;
    localparam logic [11:0] E_RESET   = 12'b0_1111_1111_000;
    localparam logic [11:0] E_LU      = 12'b0_0111_0100_000;
    localparam logic [11:0] E_BR      = 12'b1_1111_1100_000;
    localparam logic [11:0] E_IMISS   = 12'b0_1111_1000_000;
    localparam logic [11:0] E_FREEZE  = 12'b0_0001_0001_100;
    localparam logic [11:0] E_REL     = 12'b1_1111_0000_100;
    localparam logic [11:0] E_HALT    = 12'b0_0000_0000_010;
    localparam logic [11:0] E_FRZ_ERR = 12'b0_0001_0001_101;
    localparam logic [11:0] E_REL_ERR = 12'b1_1111_0000_101;
    localparam logic [11:0] E_NRM_ERR = 12'b1_1111_0000_001;
    localparam logic [11:0] E_RST_ERR = 12'b0_1111_1111_001;

    typedef struct packed {
        logic [11:0] outv;
        logic        perf;
        logic [31:0] lu;
        logic [31:0] dw;
        logic [31:0] br;
    } exp_t;

    logic CLK;
    hazard_unit_if hif (.CLK(CLK));

    exp_t  exp_q[$];
    string name_q[$];
    logic  chk_vld;
    int    checks;
    int    failures;
    exp_t  mon_e;
    string mon_nm;
    logic [11:0] mon_got;

    hazard_unit #(.WAIT_TIMEOUT(4), .TMR_W(8)) dut (
        .CLK         (CLK),
        .RST         (hif.RST),
        .id_rs       (hif.id_rs),
        .id_rt       (hif.id_rt),
        .id_use_rs   (hif.id_use_rs),
        .id_use_rt   (hif.id_use_rt),
        .ex_rt       (hif.ex_rt),
        .ex_memread  (hif.ex_memread),
        .ex_pcsrc    (hif.ex_pcsrc),
        .mem_dren    (hif.mem_dren),
        .mem_dwen    (hif.mem_dwen),
        .dhit        (hif.dhit),
        .ihit        (hif.ihit),
        .mem_halt    (hif.mem_halt),
        .pc_en       (hif.pc_en),
        .ifid_en     (hif.ifid_en),
        .idex_en     (hif.idex_en),
        .exmem_en    (hif.exmem_en),
        .memwb_en    (hif.memwb_en),
        .ifid_flush  (hif.ifid_flush),
        .idex_flush  (hif.idex_flush),
        .exmem_flush (hif.exmem_flush),
        .memwb_flush (hif.memwb_flush),
        .dwait       (hif.dwait),
        .halted      (hif.halted),
        .timeout_err (hif.timeout_err)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .stall_lu_cnt (hif.stall_lu_cnt),
        .stall_dw_cnt (hif.stall_dw_cnt),
        .flush_br_cnt (hif.flush_br_cnt)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Monitor: outputs are combinational, so every checked cycle presents a
    // response; pop one expectation per cycle and compare away from posedge.
    always @(negedge CLK) begin
        if (chk_vld) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL scoreboard_empty got=none exp=entry");
            end else begin
                mon_e   = exp_q.pop_front();
                mon_nm  = name_q.pop_front();
                mon_got = {hif.pc_en, hif.ifid_en, hif.idex_en, hif.exmem_en, hif.memwb_en,
                           hif.ifid_flush, hif.idex_flush, hif.exmem_flush, hif.memwb_flush,
                           hif.dwait, hif.halted, hif.timeout_err};
                checks++;
                if (mon_got !== mon_e.outv) begin
                    failures++;
                    $display("FAIL %s got=%b exp=%b", mon_nm, mon_got, mon_e.outv);
                end
`ifdef HAZARD_PERF_CNT_EN
                if (mon_e.perf) begin
                    checks++;
                    if ({hif.stall_lu_cnt, hif.stall_dw_cnt, hif.flush_br_cnt} !==
                        {mon_e.lu, mon_e.dw, mon_e.br}) begin
                        failures++;
                        $display("FAIL %s_perf got lu=%0d dw=%0d br=%0d exp lu=%0d dw=%0d br=%0d",
                                 mon_nm, hif.stall_lu_cnt, hif.stall_dw_cnt, hif.flush_br_cnt,
                                 mon_e.lu, mon_e.dw, mon_e.br);
                    end
                end
`endif
            end
        end
    end

    task automatic idle();
        hif.RST        = 1'b0;
        hif.id_rs      = '0;
        hif.id_rt      = '0;
        hif.id_use_rs  = 1'b0;
        hif.id_use_rt  = 1'b0;
        hif.ex_rt      = '0;
        hif.ex_memread = 1'b0;
        hif.ex_pcsrc   = 1'b0;
        hif.mem_dren   = 1'b0;
        hif.mem_dwen   = 1'b0;
        hif.dhit       = 1'b0;
        hif.ihit       = 1'b1;
        hif.mem_halt   = 1'b0;
    endtask

    // Push the expected response for the inputs currently applied, then
    // advance one clock.
    task automatic step(input logic [11:0] ev, input string nm,
                        input logic pv = 1'b0, input logic [31:0] elu = 32'd0,
                        input logic [31:0] edw = 32'd0, input logic [31:0] ebr = 32'd0);
        exp_t e;
        e.outv = ev;
        e.perf = pv;
        e.lu   = elu;
        e.dw   = edw;
        e.br   = ebr;
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge CLK);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        chk_vld  = 1'b0;
        idle();
        hif.RST  = 1'b1;
        @(posedge CLK);
        #1;
        chk_vld = 1'b1;

        // Reset forcing
        idle(); hif.RST = 1'b1;        step(E_RESET, "reset_a");
        idle(); hif.RST = 1'b1;        step(E_RESET, "reset_b");
        idle();                        step(E_NORMAL, "run_idle");
        idle(); hif.mem_dwen = 1'b1; hif.dhit = 1'b1;
                                       step(E_NORMAL, "dhit_zero_wait");

        // Load-use
        idle(); hif.ex_memread = 1'b1; hif.ex_rt = 5'd5; hif.id_rs = 5'd5; hif.id_use_rs = 1'b1;
                                       step(E_LU, "lu_stall");
        idle(); hif.id_rs = 5'd5; hif.id_use_rs = 1'b1;
                                       step(E_NORMAL, "lu_resolved");
        idle(); hif.ex_memread = 1'b1; hif.ex_rt = 5'd0; hif.id_rs = 5'd0; hif.id_use_rs = 1'b1;
                                       step(E_NORMAL, "lu_r0");
        idle(); hif.ex_memread = 1'b1; hif.ex_rt = 5'd7; hif.id_rt = 5'd7;
                hif.id_rs = 5'd3; hif.id_use_rs = 1'b1;
                                       step(E_NORMAL, "lu_rt_unused");
        idle(); hif.ex_memread = 1'b1; hif.ex_rt = 5'd7; hif.id_rt = 5'd7; hif.id_use_rt = 1'b1;
                                       step(E_LU, "lu_rt");

        // Redirect beats load-use and fetch miss
        idle(); hif.ex_pcsrc = 1'b1; hif.ex_memread = 1'b1; hif.ex_rt = 5'd5;
                hif.id_rs = 5'd5; hif.id_use_rs = 1'b1; hif.ihit = 1'b0;
                                       step(E_BR, "br_over_lu");
        idle(); hif.ihit = 1'b0;       step(E_IMISS, "imiss");

        // Dcache miss, three waiting cycles then release
        idle(); hif.mem_dren = 1'b1;   step(E_FREEZE, "dmiss_entry");
        idle(); hif.mem_dren = 1'b1;   step(E_FREEZE, "dmiss_wait1");
        idle(); hif.mem_dren = 1'b1; hif.ex_pcsrc = 1'b1; hif.mem_halt = 1'b1;
                                       step(E_FREEZE, "dmiss_wait2");
        idle(); hif.mem_dren = 1'b1; hif.dhit = 1'b1;
                                       step(E_REL, "dmiss_release");
        idle();                        step(E_NORMAL, "dmiss_back_run", 1'b1, 32'd2, 32'd4, 32'd1);

        // Watchdog with WAIT_TIMEOUT=4
        idle(); hif.mem_dren = 1'b1;   step(E_FREEZE, "wd_entry");
        idle(); hif.mem_dren = 1'b1;   step(E_FREEZE, "wd_w1");
        idle(); hif.mem_dren = 1'b1;   step(E_FREEZE, "wd_w2");
        idle(); hif.mem_dren = 1'b1;   step(E_FREEZE, "wd_w3");
        idle(); hif.mem_dren = 1'b1;   step(E_FREEZE, "wd_w4");
        idle(); hif.mem_dren = 1'b1;   step(E_FRZ_ERR, "wd_err1");
        idle(); hif.mem_dren = 1'b1;   step(E_FRZ_ERR, "wd_err2");
        idle(); hif.mem_dren = 1'b1; hif.dhit = 1'b1;
                                       step(E_REL_ERR, "wd_release");
        idle();                        step(E_NRM_ERR, "wd_sticky");
        idle(); hif.RST = 1'b1;        step(E_RST_ERR, "wd_rst");
        idle();                        step(E_NORMAL, "wd_cleared", 1'b1, 32'd0, 32'd0, 32'd0);

        // Halt
        idle(); hif.ex_pcsrc = 1'b1;   step(E_BR, "br2");
        idle(); hif.mem_halt = 1'b1;   step(E_NORMAL, "halt_entry");
        idle(); hif.ex_pcsrc = 1'b1; hif.mem_dren = 1'b1;
                                       step(E_HALT, "halted_a");
        idle(); hif.ex_pcsrc = 1'b1; hif.ex_memread = 1'b1; hif.ex_rt = 5'd2;
                hif.id_rs = 5'd2; hif.id_use_rs = 1'b1;
                                       step(E_HALT, "halted_b", 1'b1, 32'd0, 32'd0, 32'd1);
        idle(); hif.RST = 1'b1;        step(E_RESET, "halt_rst");
        idle();                        step(E_NORMAL, "halt_released");

        chk_vld = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
